poly_mult_fold_reduce: RTL
==========================

# poly_mult_fold_reduce

Downstream stage of the polynomial-multiplication systolic array. It captures the array's full linear product (2D-1 coefficients, each 2N bits) a fixed number of cycles after the array is loaded. It folds the product back into D coefficients modulo x^D+1 (or x^D-1) and reduces each coefficient modulo Q. It then streams the D reduced coefficients out one per transfer over a valid/ready handshake.

## Interface
Parameters:
- D, 4, polynomial length; matches the array's D.
- N, 4, coefficient width in bits; matches the array's N.
- Q, 13, modulus; 2 <= Q < 2^N.
- LAT, 4, cycles from start to a valid array product; LAT >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  pulse: array inputs applied this cycle; sampled only in IDLE.
- p  input  2N*(2D-1)  array product; slot k = p[2N*(k+1)-1:2N*k] is the unsigned coefficient of x^k.
- busy  output  1  high in any state other than IDLE.
- out_valid  output  1  out_coef/out_idx valid.
- out_ready  input  1  consumer accepts.
- out_coef  output  N  reduced coefficient, range 0..Q-1.
- out_idx  output  clog2(D)  coefficient index.
- out_last  output  1  high with out_idx = D-1.

## Operation
- FSM states: IDLE -> WAIT -> FOLD -> EMIT -> IDLE.
- IDLE: on start=1, clear the wait counter and go to WAIT.
- WAIT: the counter increments each cycle. On the cycle the counter reaches LAT-1, register all 2D-1 slots of p into the capture bank and go to FOLD.
- FOLD: one index k per cycle, k = 0..D-1. Compute a = slot_k mod Q and b = slot_{k+D} mod Q (b = 0 for k = D-1). Write r_k into the result buffer. After k = D-1, go to EMIT.
- Negacyclic fold: r_k = (a - b) mod Q, computed as a - b if a >= b, else a - b + Q.
- Cyclic fold: r_k = (a + b) mod Q, computed as a + b - Q if a + b >= Q, else a + b.
- All slots are treated as unsigned 2N-bit values. No sign interpretation and no overflow detection.
- EMIT: present r_0..r_{D-1} in index order.
  - An index advances only on a cycle where out_valid && out_ready.
  - While out_valid=1 && out_ready=0, out_coef, out_idx and out_last hold stable.
  - The transfer with out_idx = D-1 returns the FSM to IDLE.
- A start pulse outside IDLE is ignored and not queued.
- A start pulse in the same cycle as the final transfer is ignored; busy is still high in that cycle.
- Reset: rst low at any time, including mid-WAIT, FOLD or EMIT, returns the FSM to IDLE immediately. It clears the counters and aborts the partial result with no output.
- Reset values: busy=0, out_valid=0, out_coef=0, out_idx=0, out_last=0. The capture bank and result buffer also reset to 0.

## Timing
- Let E0 be the edge that samples start=1 in IDLE. busy=1 after E0.
- p is captured at edge E_LAT. The upstream array must hold the product on p during the cycle before E_LAT.
- FOLD occupies the cycles ending at edges E_{LAT+1}..E_{LAT+D}.
- out_valid=1 after edge E_{LAT+D}, so the first coefficient is available LAT+D cycles after start.
- With out_ready held at 1, one coefficient transfers per cycle. The last transfer completes at edge E_{LAT+2D}, after which busy=0.
- With continuous out_ready, back-to-back operations need start one cycle after busy falls. The minimum period is LAT+2D+1 cycles.
- out_valid, out_coef, out_idx, out_last and busy are registered outputs with no combinational path from inputs. out_valid does not depend on out_ready.

## Configuration
- POLY_FOLD_NEGACYCLIC_EN defined: fold modulo x^D+1, using the subtractive rule above.
- POLY_FOLD_NEGACYCLIC_EN undefined: fold modulo x^D-1, using the additive rule above.
- Interface, FSM and timing are identical in both builds.

## Test plan
All scenarios use D=4, N=4, Q=13, LAT=4.

- Basic product, negacyclic: slots = 1,2,1,0,0,0,0 (product (1+x)^2), start pulse, out_ready=1. Emits 1,2,1,0 with idx 0..3 and out_last on idx 3. First out_valid 8 cycles after start; busy falls 12 cycles after start.
- Negacyclic wrap: slots = 0,0,0,0,1,0,0 (x^3·x). Emits 12,0,0,0 with the macro defined, and 1,0,0,0 without it.
- Saturated slots: all slots = 255 (255 mod 13 = 8). Negacyclic emits 0,0,0,8; cyclic emits 3,3,3,8.
- Backpressure: scenario 1 with out_ready toggling 0,0,1,0,1,1,0,1. The coefficient stays stable while out_ready=0, exactly 4 transfers occur in order, and then busy=0.
- Ignored start: pulse start during WAIT and again during EMIT. Exactly one 4-coefficient burst is produced, and busy returns to 0 with no second burst.
- Reset mid-EMIT: assert rst low after the idx 1 transfer. busy and out_valid go to 0 immediately. A new start after rst goes high produces a fresh, correct burst starting at idx 0.

Source files
------------

// File: rtl/poly_mult_fold_reduce_if.sv
// poly_mult_fold_reduce_if: valid/ready stream carrying one reduced
// coefficient per transfer, with its index and a last-coefficient flag.
interface poly_mult_fold_reduce_if #(
    parameter int N     = 4,
    parameter int IDX_W = 2
);
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_coef;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    // Producer side: the fold/reduce stage.
    modport master (
        output out_valid,
        output out_coef,
        output out_idx,
        output out_last,
        input  out_ready
    );

    // Consumer side.
    modport slave (
        input  out_valid,
        input  out_coef,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/poly_mult_fold_reduce.sv
// poly_mult_fold_reduce: captures the systolic array's 2D-1 product slots
// LAT cycles after start, folds them into D coefficients, reduces each
// modulo Q and streams them out in index order.
// Build option: define POLY_FOLD_NEGACYCLIC_EN to fold modulo x^D+1
// (r_k = slot_k - slot_{k+D}); leave it undefined to fold modulo x^D-1
// (r_k = slot_k + slot_{k+D}).
module poly_mult_fold_reduce #(
    parameter int D   = 4,
    parameter int N   = 4,
    parameter int Q   = 13,
    parameter int LAT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2*N*(2*D-1)-1:0]  p,
    output logic                    busy,
    poly_mult_fold_reduce_if.master out_bus
);
    localparam int SLOTS  = 2 * D - 1;
    localparam int IDX_W  = (D > 1) ? $clog2(D) : 1;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [2*N-1:0] Q_WIDE = (2 * N)'(Q);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FOLD,
        S_EMIT
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]  wait_cnt;
    logic [IDX_W-1:0]  fold_idx;
    logic [2*N-1:0]    cap [SLOTS];
    logic [N-1:0]      res [D];

    logic              wait_done;
    logic              fold_last;
    logic              xfer;
    logic              last_xfer;
    logic [SLOT_W-1:0] lo_sel;
    logic [SLOT_W-1:0] hi_sel;
    logic [N-1:0]      a_mod;
    logic [N-1:0]      b_mod;
    logic [N-1:0]      r_val;

    // Unsigned 2N-bit slot reduced modulo Q; the result always fits in N bits.
    function automatic logic [N-1:0] mod_q(input logic [2*N-1:0] v);
        return N'(v % Q_WIDE);
    endfunction

    assign wait_done = (state == S_WAIT) && (wait_cnt == CNT_W'(LAT - 1));
    assign fold_last = (state == S_FOLD) && (fold_idx == IDX_W'(D - 1));
    assign xfer      = out_bus.out_valid && out_bus.out_ready;
    assign last_xfer = xfer && out_bus.out_last;

    // Fold datapath: reduce slot k and slot k+D, then combine them mod Q.
    // NOTE: every variable in an always_comb gets a value before any branch,
    // otherwise a path that leaves it unassigned infers a latch.
    always_comb begin
        lo_sel = SLOT_W'(fold_idx);
        hi_sel = '0;
        b_mod  = '0;
        a_mod  = mod_q(cap[lo_sel]);
        // Coefficient D-1 has no partner slot 2D-1.
        if (fold_idx != IDX_W'(D - 1)) begin
            hi_sel = lo_sel + SLOT_W'(D);
            b_mod  = mod_q(cap[hi_sel]);
        end
`ifdef POLY_FOLD_NEGACYCLIC_EN
        // a - b + Q stays in 0..Q-1, so wrapping in N bits is harmless.
        if (a_mod >= b_mod) r_val = a_mod - b_mod;
        else                r_val = a_mod + N'(Q) - b_mod;
`else
        begin
            logic [N:0] sum;
            sum = {1'b0, a_mod} + {1'b0, b_mod};
            if (sum >= (N + 1)'(Q)) r_val = N'(sum - (N + 1)'(Q));
            else                    r_val = N'(sum);
        end
`endif
    end

    // Next-state logic; start is only honoured in IDLE and never queued.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start)     next_state = S_WAIT;
            S_WAIT:  if (wait_done) next_state = S_FOLD;
            S_FOLD:  if (fold_last) next_state = S_EMIT;
            S_EMIT:  if (last_xfer) next_state = S_IDLE;
            default:                next_state = S_IDLE;
        endcase
    end

    // State register; busy is registered from the upcoming state.
    // NOTE: sequential state uses <= so every flop samples pre-edge values,
    // independent of the order of statements or blocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != S_IDLE);
        end
    end

    // Counters, capture bank, result buffer and registered stream outputs.
    // NOTE: the capture bank and result buffer are reset explicitly so a
    // reset mid-operation leaves no stale coefficients behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt          <= '0;
            fold_idx          <= '0;
            out_bus.out_valid <= 1'b0;
            out_bus.out_coef  <= '0;
            out_bus.out_idx   <= '0;
            out_bus.out_last  <= 1'b0;
            for (int s = 0; s < SLOTS; s++) cap[s] <= '0;
            for (int k = 0; k < D; k++)     res[k] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    fold_idx <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (wait_done) begin
                        for (int s = 0; s < SLOTS; s++) cap[s] <= p[2*N*s +: 2*N];
                        fold_idx <= '0;
                    end
                end
                S_FOLD: begin
                    res[fold_idx] <= r_val;
                    if (fold_last) begin
                        fold_idx          <= '0;
                        out_bus.out_valid <= 1'b1;
                        out_bus.out_idx   <= '0;
                        out_bus.out_last  <= (D == 1);
                        // With D == 1 the only coefficient is the one just folded.
                        out_bus.out_coef  <= (D == 1) ? r_val : res[0];
                    end else begin
                        fold_idx <= fold_idx + IDX_W'(1);
                    end
                end
                S_EMIT: begin
                    if (xfer) begin
                        if (out_bus.out_last) begin
                            out_bus.out_valid <= 1'b0;
                            out_bus.out_last  <= 1'b0;
                            out_bus.out_idx   <= '0;
                        end else begin
                            out_bus.out_idx  <= out_bus.out_idx + IDX_W'(1);
                            out_bus.out_coef <= res[out_bus.out_idx + IDX_W'(1)];
                            out_bus.out_last <= (out_bus.out_idx + IDX_W'(1) == IDX_W'(D - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
